// File: rtl/cache_arbiter_pkg.sv
// cache_ctrl_pkg: shared widths, FSM state type and grant helper for the cache arbiter.
package cache_ctrl_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 5;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STALL, RESP} state_t;

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: requester-side and cache-side signals of the two-port cache arbiter.
interface cache_arbiter_if import cache_ctrl_pkg::*; #(parameter int CNT_W = 8);
    logic [1:0]        req;
    logic [1:0]        req_write;
    logic [ADDR_W-1:0] req_address0;
    logic [ADDR_W-1:0] req_address1;
    logic [DATA_W-1:0] req_write_data0;
    logic [DATA_W-1:0] req_write_data1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DATA_W-1:0] read_data;
    logic              hit;
    logic              cache_strobe;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_address;
    logic [DATA_W-1:0] cache_write_data;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_read_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  req, req_write, req_address0, req_address1, req_write_data0, req_write_data1,
               cache_hit, cache_read_data,
        output gnt, done, read_data, hit, cache_strobe, cache_write, cache_address,
               cache_write_data, hit_count, miss_count
    );

    modport master (
        output req, req_write, req_address0, req_address1, req_write_data0, req_write_data1,
               cache_hit, cache_read_data,
        input  gnt, done, read_data, hit, cache_strobe, cache_write, cache_address,
               cache_write_data, hit_count, miss_count
    );
endinterface

// File: rtl/cache_arbiter_arb.sv
// rr_arbiter2: two-way round-robin arbiter; a tie goes to the port not granted last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic last;

    always_comb gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};

    // last resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= 1'b1;
        else if (adv)
            last <= gnt[1];
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serves one of two ports at a time against a single cache, with a fixed miss stall.
module cache_arbiter import cache_ctrl_pkg::*; #(
    parameter int MISS_PENALTY = 4,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);
    state_t            state;
    logic              port;
    logic [3:0]        stall_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  mc;
    logic [1:0]        win;
    logic              adv;

    assign adv            = state == IDLE && |bus.req;
    assign bus.hit_count  = hc;
    assign bus.miss_count = mc;

    rr_arbiter2 u_arb (.clk(clk), .rst_n(rst_n), .req(bus.req), .adv(adv), .gnt(win));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            port                 <= 1'b0;
            stall_cnt            <= '0;
            rdata_q              <= '0;
            hc                   <= '0;
            mc                   <= '0;
            bus.gnt              <= '0;
            bus.done             <= '0;
            bus.read_data        <= '0;
            bus.hit              <= 1'b0;
            bus.cache_strobe     <= 1'b0;
            bus.cache_write      <= 1'b0;
            bus.cache_address    <= '0;
            bus.cache_write_data <= '0;
        end else begin
            bus.gnt          <= '0;
            bus.done         <= '0;
            bus.cache_strobe <= 1'b0;
            case (state)
                IDLE: if (adv) begin
                    state                <= ISSUE;
                    port                 <= win[1];
                    bus.gnt              <= win;
                    bus.cache_strobe     <= 1'b1;
                    bus.cache_write      <= win[1] ? bus.req_write[1] : bus.req_write[0];
                    bus.cache_address    <= win[1] ? bus.req_address1 : bus.req_address0;
                    bus.cache_write_data <= win[1] ? bus.req_write_data1 : bus.req_write_data0;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    rdata_q <= bus.cache_read_data;
                    if (bus.cache_hit) begin
                        if (!(&hc)) hc <= hc + 1'b1;
                        state    <= RESP;
                        bus.done <= onehot(port);
                        bus.hit  <= 1'b1;
                        if (!bus.cache_write) bus.read_data <= bus.cache_read_data;
                    end else begin
                        if (!(&mc)) mc <= mc + 1'b1;
                        state     <= STALL;
                        stall_cnt <= 4'(MISS_PENALTY - 1);
                    end
                end
                STALL: if (stall_cnt == '0) begin
                    state    <= RESP;
                    bus.done <= onehot(port);
                    bus.hit  <= 1'b0;
                    if (!bus.cache_write) bus.read_data <= rdata_q;
                end else begin
                    stall_cnt <= stall_cnt - 1'b1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed vectors, corner sequences and a randomized transaction-level model.
module tb_cache_arbiter;
    import cache_ctrl_pkg::*;

    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.CNT_W(8)) b();
    cache_arbiter_if #(.CNT_W(2)) b2();

    logic [DATA_W-1:0] mem [32];
    logic [31:0]       hitmap;

    assign b.cache_hit          = hitmap[b.cache_address];
    assign b.cache_read_data    = mem[b.cache_address];
    assign b2.cache_hit         = hitmap[b2.cache_address];
    assign b2.cache_read_data   = mem[b2.cache_address];
    assign b2.req               = b.req;
    assign b2.req_write         = b.req_write;
    assign b2.req_address0      = b.req_address0;
    assign b2.req_address1      = b.req_address1;
    assign b2.req_write_data0   = b.req_write_data0;
    assign b2.req_write_data1   = b.req_write_data1;

    cache_arbiter #(.MISS_PENALTY(P), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    cache_arbiter #(.MISS_PENALTY(P), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] wr;
        logic [4:0] a0, a1, d0, d1;
        int         port;
        int         lat;
        logic [4:0] rd;
        logic       h;
        int         hc;
        int         mc;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [4:0] a0, a1, d0, d1);
        b.req             = r;
        b.req_write       = w;
        b.req_address0    = a0;
        b.req_address1    = a1;
        b.req_write_data0 = d0;
        b.req_write_data1 = d1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string nm, output int c);
        c = 0;
        do begin
            step();
            c++;
            chk({nm, "_nodone"}, b.done, 0);
        end while (b.gnt == 2'b00 && c < 12);
    endtask

    task automatic wait_done(input string nm, output int c);
        c = 0;
        do begin
            step();
            c++;
            chk({nm, "_quiet"}, {b.gnt, b.cache_strobe}, 0);
        end while (b.done == 2'b00 && c < 30);
    endtask

    task automatic run(input vec_t v, input string nm);
        int c;
        drive(v.req, v.wr, v.a0, v.a1, v.d0, v.d1);
        wait_gnt(nm, c);
        chk({nm, "_gnt"}, b.gnt, v.port ? 2 : 1);
        chk({nm, "_strobe"}, b.cache_strobe, 1);
        chk({nm, "_cwrite"}, b.cache_write, v.wr[v.port]);
        chk({nm, "_caddr"}, b.cache_address, v.port ? v.a1 : v.a0);
        chk({nm, "_cwdata"}, b.cache_write_data, v.port ? v.d1 : v.d0);
        drive(2'b00, ~v.wr, ~v.a0, ~v.a1, ~v.d0, ~v.d1);
        wait_done(nm, c);
        chk({nm, "_lat"}, c, v.lat);
        chk({nm, "_done"}, b.done, v.port ? 2 : 1);
        chk({nm, "_rdata"}, b.read_data, v.rd);
        chk({nm, "_hit"}, b.hit, v.h);
        chk({nm, "_hitcnt"}, b.hit_count, v.hc);
        chk({nm, "_misscnt"}, b.miss_count, v.mc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        hitmap = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        hitmap[9] = 1'b1;
        hitmap[3] = 1'b1;
        mem[9]    = 5'b01001;
        mem[3]    = 5'h15;
        mem[4]    = 5'h0a;

        vt[0] = '{2'b01, 2'b00, 5'd9, 5'd0, 5'd0, 5'd0,    0, 2, 5'd9,  1'b1, 1, 0};
        vt[1] = '{2'b10, 2'b10, 5'd0, 5'd4, 5'd0, 5'b00111, 1, 6, 5'd9,  1'b0, 1, 1};
        vt[2] = '{2'b11, 2'b00, 5'd3, 5'd4, 5'd0, 5'd0,    0, 2, 5'h15, 1'b1, 2, 1};
        vt[3] = '{2'b11, 2'b00, 5'd3, 5'd4, 5'd0, 5'd0,    1, 6, 5'h0a, 1'b0, 2, 2};
        vt[4] = '{2'b10, 2'b00, 5'd0, 5'd9, 5'd0, 5'd0,    1, 2, 5'd9,  1'b1, 3, 2};
        vt[5] = '{2'b11, 2'b01, 5'd3, 5'd9, 5'h1f, 5'd0,   0, 2, 5'd9,  1'b1, 4, 2};

        reset_dut();
        chk("rst_gnt", b.gnt, 0);
        chk("rst_done", b.done, 0);
        chk("rst_strobe", b.cache_strobe, 0);
        chk("rst_rdata", b.read_data, 0);
        chk("rst_hit", b.hit, 0);
        chk("rst_hitcnt", b.hit_count, 0);
        chk("rst_misscnt", b.miss_count, 0);

        for (int i = 0; i < 6; i++) run(vt[i], $sformatf("vec%0d", i));
        chk("vec_sat_hit", b2.hit_count, 3);
        chk("vec_sat_miss", b2.miss_count, 2);

        // both ports request continuously, all hits
        reset_dut();
        drive(2'b11, 2'b00, 5'd9, 5'd3, 5'd0, 5'd0);
        for (int g = 0; g < 6; g++) begin
            wait_gnt("b2b", c);
            chk($sformatf("b2b%0d_gnt", g), b.gnt, (g % 2) ? 2 : 1);
            if (g > 0) chk($sformatf("b2b%0d_gap", g), c + 2, 4);
            wait_done("b2b", c);
            chk($sformatf("b2b%0d_done", g), b.done, (g % 2) ? 2 : 1);
            chk($sformatf("b2b%0d_rdata", g), b.read_data, (g % 2) ? 5'h15 : 5'd9);
            if (g == 4) begin
                chk("sat5_hit", b2.hit_count, 3);
                chk("sat5_miss", b2.miss_count, 0);
            end
        end
        chk("b2b_hitcnt", b.hit_count, 6);

        // reset asserted in the middle of a miss stall
        drive(2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        reset_dut();
        drive(2'b01, 2'b00, 5'd4, 5'd0, 5'd0, 5'd0);
        wait_gnt("rstall", c);
        chk("rstall_gnt", b.gnt, 1);
        step();
        step();
        step();
        chk("rstall_misscnt_pre", b.miss_count, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstall_gnt0", b.gnt, 0);
        chk("rstall_done0", b.done, 0);
        chk("rstall_strobe0", b.cache_strobe, 0);
        chk("rstall_rdata0", b.read_data, 0);
        chk("rstall_hit0", b.hit, 0);
        chk("rstall_misscnt0", b.miss_count, 0);
        drive(2'b11, 2'b00, 5'd9, 5'd3, 5'd0, 5'd0);
        step();
        chk("rstall_hold_done", b.done, 0);
        step();
        rst_n = 1'b1;
        wait_gnt("rstall_re", c);
        chk("rstall_re_gnt", b.gnt, 1);
        drive(2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        wait_done("rstall_re", c);
        chk("rstall_re_done", b.done, 1);
        chk("rstall_re_rdata", b.read_data, 9);

        // randomized traffic against a transaction-level model
        begin
            int         ready = 0;
            int         ge = -100;
            int         de = -100;
            int         p = 0;
            int         hc = 0;
            int         mc = 0;
            logic       last = 1'b1;
            logic       wr = 1'b0;
            logic       h = 1'b0;
            logic       eh = 1'b0;
            logic [4:0] ad = '0;
            logic [4:0] wd = '0;
            logic [4:0] erd = '0;
            logic [1:0] cr, cw;
            logic [4:0] ca0, ca1, cd0, cd1;
            drive(2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
            reset_dut();
            hitmap = $urandom;
            for (int i = 0; i < 32; i++) mem[i] = 5'($urandom);
            cr = 2'($urandom); cw = 2'($urandom);
            ca0 = 5'($urandom); ca1 = 5'($urandom); cd0 = 5'($urandom); cd1 = 5'($urandom);
            drive(cr, cw, ca0, ca1, cd0, cd1);
            for (int k = 0; k < 2000; k++) begin
                step();
                if (k >= ready && cr != 2'b00) begin
                    p    = cr == 2'b01 ? 0 : cr == 2'b10 ? 1 : (last ? 0 : 1);
                    last = p == 1;
                    wr   = cw[p];
                    ad   = p ? ca1 : ca0;
                    wd   = p ? cd1 : cd0;
                    h    = hitmap[ad];
                    ge   = k;
                    de   = k + 2 + (h ? 0 : P);
                    ready = de + 2;
                end
                if (k == ge + 2) begin
                    if (h) hc++;
                    else mc++;
                end
                if (k == de) begin
                    eh = h;
                    if (!wr) erd = mem[ad];
                end
                chk("rnd_gnt", b.gnt, k == ge ? (p ? 2 : 1) : 0);
                chk("rnd_strobe", b.cache_strobe, k == ge ? 1 : 0);
                if (k == ge) begin
                    chk("rnd_cwrite", b.cache_write, wr);
                    chk("rnd_caddr", b.cache_address, ad);
                    chk("rnd_cwdata", b.cache_write_data, wd);
                end
                chk("rnd_done", b.done, k == de ? (p ? 2 : 1) : 0);
                chk("rnd_rdata", b.read_data, erd);
                chk("rnd_hit", b.hit, eh);
                chk("rnd_hitcnt", b.hit_count, hc > 255 ? 255 : hc);
                chk("rnd_misscnt", b.miss_count, mc > 255 ? 255 : mc);
                chk("rnd_hitcnt2", b2.hit_count, hc > 3 ? 3 : hc);
                chk("rnd_misscnt2", b2.miss_count, mc > 3 ? 3 : mc);
                cr  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
                cw  = 2'($urandom);
                ca0 = 5'($urandom); ca1 = 5'($urandom); cd0 = 5'($urandom); cd1 = 5'($urandom);
                drive(cr, cw, ca0, ca1, cd0, cd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter MISS_PENALTY, default 4, stall cycles added to any cache miss (legal 1..15).
REQ-002 Parameter CNT_W, default 8, width of hit/miss statistics counters.
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Req  input  2  per-port request; bit p = port p.
REQ-006 ReqWrite  input  2  per-port op; 1 = write, 0 = read.
REQ-007 ReqAddress0, ReqAddress1  input  5 each  per-port word address.
REQ-008 ReqWriteData0, ReqWriteData1  input  5 each  per-port write word.
REQ-009 Gnt  output  2  one-hot, one-cycle grant pulse.
REQ-010 Done  output  2  one-hot, one-cycle completion pulse.
REQ-011 ReadData  output  5  read result, valid while Done is high, then held.
REQ-012 Hit  output  1  hit status of the completed access, valid while Done is high, then held.
REQ-013 CacheStrobe  output  1  one-cycle access strobe to the cache.
REQ-014 CacheWrite, CacheAddress, CacheWriteData  output  1/5/5  latched access to the cache.
REQ-015 CacheHit, CacheReadData  input  1/5  cache response, valid in the cycle after CacheStrobe.
REQ-016 HitCount, MissCount  output  CNT_W each  statistics counters.

Function
REQ-017 The FSM states SHALL be IDLE, ISSUE, WAIT, STALL, RESP; all outputs SHALL be registered.
REQ-018 In IDLE with any Req bit set, the block SHALL select a port, latch that port's op/address/data, and enter ISSUE with Gnt[p]=1 for the ISSUE cycle only.
REQ-019 Arbitration SHALL be round-robin: a single requester wins; when both request, the port not granted last wins; LastGrant updates on every grant.
REQ-020 In ISSUE, CacheStrobe SHALL be 1 with the latched CacheWrite/CacheAddress/CacheWriteData; next state SHALL be WAIT.
REQ-021 In WAIT, the block SHALL sample CacheHit and CacheReadData; on a hit it SHALL go to RESP, and on a miss it SHALL go to STALL.
REQ-022 STALL SHALL last exactly MISS_PENALTY cycles, counted by a down-counter, then go to RESP.
REQ-023 In RESP, Done[p]=1 for the granted port for one cycle with ReadData/Hit; next state SHALL be IDLE.
REQ-024 On a hit, Done SHALL be asserted 2 cycles after Gnt; on a miss, Done SHALL be asserted 2+MISS_PENALTY cycles after Gnt; a read or write SHALL have identical timing.
REQ-025 For writes, ReadData SHALL hold its previous value; Hit SHALL report CacheHit.
REQ-026 Req SHALL be sampled only in IDLE; a Req that drops before grant is never served; Req/data changes after Gnt SHALL be ignored.
REQ-027 A requester holding Req through Done SHALL be re-eligible in the next IDLE cycle, so back-to-back throughput is one access per 4 cycles on hits.
REQ-028 HitCount or MissCount SHALL increment by one in WAIT per access and saturate at all-ones.
REQ-029 CacheStrobe, Gnt and Done SHALL never be asserted outside ISSUE, ISSUE and RESP respectively.

Reset
REQ-030 Reset_n low SHALL asynchronously force IDLE, Gnt=0, Done=0, CacheStrobe=0, ReadData=0, Hit=0, counters=0, stall counter=0, and LastGrant=1 so that port 0 wins the first tie.
REQ-031 Reset in any state SHALL abort the in-flight access with no Done; the requester SHALL re-request.

Structure
REQ-032 Package cache_ctrl_pkg SHALL hold ADDR_W=5, DATA_W=5, and the FSM state enum.
REQ-033 Sub-module rr_arbiter2 (2-way round-robin with LastGrant register, advance enable) SHALL implement REQ-019.

Verification
REQ-034 Port 0 reads address 9 with CacheHit=1 and data 01001: Gnt0 in cycle N, CacheStrobe in cycle N, Done0 in cycle N+2, ReadData=01001, Hit=1, HitCount=1.
REQ-035 Port 1 writes address 4, data 00111, with CacheHit=0 and MISS_PENALTY=4: CacheWrite=1, CacheWriteData=00111, Done1 in cycle N+6, Hit=0, MissCount=1.
REQ-036 Both ports request continuously for 6 grants: grant order is 0,1,0,1,0,1 and Done pulses never overlap.
REQ-037 Reset_n is pulsed low during STALL: outputs return to 0 immediately, no Done is asserted, and the next simultaneous request grants port 0.
REQ-038 With CNT_W=2, five consecutive hits leave HitCount=3 and MissCount=0.
